// File: rtl/calf_nic_pkg.sv
// Shared flit geometry and pack/unpack helpers for the CALF node interface.
package calf_nic_pkg;

    localparam int FLIT_W      = 144;
    localparam int PAYLOAD_W   = 128;

    localparam int DEST_LSB    = 0;
    localparam int DEST_MSB    = 3;
    localparam int SRC_LSB     = 4;
    localparam int SRC_MSB     = 7;
    localparam int SEQ_LSB     = 8;
    localparam int SEQ_MSB     = 10;
    localparam int VALID_BIT   = 11;
    localparam int MSHR_LSB    = 12;
    localparam int MSHR_MSB    = 15;
    localparam int PAYLOAD_LSB = 16;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] data;
        logic [3:0]           mshr;
        logic [3:0]           dest;
    } inj_entry_t;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] data;
        logic [3:0]           mshr;
        logic [2:0]           seq;
        logic [3:0]           src;
    } ej_entry_t;

    function automatic logic [FLIT_W-1:0] flit_pack(
        input logic [PAYLOAD_W-1:0] data,
        input logic [3:0]           mshr,
        input logic [2:0]           seq,
        input logic [3:0]           src,
        input logic [3:0]           dest
    );
        logic [FLIT_W-1:0] f;
        f                            = '0;
        f[FLIT_W-1:PAYLOAD_LSB]      = data;
        f[MSHR_MSB:MSHR_LSB]         = mshr;
        f[VALID_BIT]                 = 1'b1;
        f[SEQ_MSB:SEQ_LSB]           = seq;
        f[SRC_MSB:SRC_LSB]           = src;
        f[DEST_MSB:DEST_LSB]         = dest;
        return f;
    endfunction

    // Destination is deliberately dropped: the router already steered the flit here.
    function automatic ej_entry_t flit_unpack(input logic [FLIT_W-1:0] flit);
        ej_entry_t e;
        e.data = flit[FLIT_W-1:PAYLOAD_LSB];
        e.mshr = flit[MSHR_MSB:MSHR_LSB];
        e.seq  = flit[SEQ_MSB:SEQ_LSB];
        e.src  = flit[SRC_MSB:SRC_LSB];
        return e;
    endfunction

endpackage

// File: rtl/calf_nic_fifo.sv
// Synchronous FIFO with same-cycle push/pop; a push while full succeeds only if the same edge pops.
module calf_nic_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/calf_nic.sv
// Node-side interface for the CALF router: injection queue toward port 4, ejection buffer toward the client.
module calf_nic
    import calf_nic_pkg::*;
#(
    parameter logic [3:0]  NODE_ID   = 4'd0,
    parameter int unsigned INJ_DEPTH = 4,
    parameter int unsigned EJ_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_dest,
    input  logic [3:0]           req_mshr,
    input  logic [PAYLOAD_W-1:0] req_data,
    output logic [FLIT_W-1:0]    port4_ci,
    input  logic                 port4_ready,
    input  logic                 port4_ack,
    input  logic [FLIT_W-1:0]    port4_co,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [3:0]           rsp_src,
    output logic [3:0]           rsp_mshr,
    output logic [2:0]           rsp_seq,
    output logic [PAYLOAD_W-1:0] rsp_data,
    output logic [7:0]           drop_count
);

    inj_entry_t inj_in;
    inj_entry_t inj_head;
    logic       inj_full;
    logic       inj_empty;
    logic       inj_push;
    logic       inj_pop;
    logic       offer;
    logic [2:0] seq;

    ej_entry_t  ej_in;
    ej_entry_t  ej_head;
    logic       ej_full;
    logic       ej_empty;
    logic       ej_push;
    logic       ej_pop;
    logic       ej_drop;

    // Injection side
    assign req_ready = !inj_full && !rst;
    assign inj_push  = req_valid && req_ready;
    assign inj_in    = '{data: req_data, mshr: req_mshr, dest: req_dest};
    assign offer     = !inj_empty && port4_ready;
    assign inj_pop   = offer && port4_ack;

    calf_nic_fifo #(
        .WIDTH ($bits(inj_entry_t)),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inj_push),
        .push_data (inj_in),
        .pop       (inj_pop),
        .head      (inj_head),
        .full      (inj_full),
        .empty     (inj_empty)
    );

    always_comb begin
        port4_ci = '0;
        if (offer) begin
            port4_ci = flit_pack(inj_head.data, inj_head.mshr, seq, NODE_ID, inj_head.dest);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          seq <= '0;
        else if (inj_pop) seq <= seq + 3'd1;
    end

    // Ejection side: capture is straight into FIFO storage, so outputs never see port4_co combinationally.
    assign ej_push = port4_co[VALID_BIT];
    assign ej_in   = flit_unpack(port4_co);
    assign ej_pop  = !ej_empty && rsp_ready;
    assign ej_drop = ej_push && ej_full && !ej_pop;

    calf_nic_fifo #(
        .WIDTH ($bits(ej_entry_t)),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ej_push),
        .push_data (ej_in),
        .pop       (ej_pop),
        .head      (ej_head),
        .full      (ej_full),
        .empty     (ej_empty)
    );

    always_ff @(posedge clk) begin
        if (rst)                               drop_count <= '0;
        else if (ej_drop && drop_count != '1)  drop_count <= drop_count + 8'd1;
    end

    assign rsp_valid = !ej_empty;
    assign rsp_data  = ej_head.data;
    assign rsp_mshr  = ej_head.mshr;
    assign rsp_seq   = ej_head.seq;
    assign rsp_src   = ej_head.src;

endmodule

// File: tb/tb_calf_nic.sv
// Scoreboard bench for calf_nic: expected flits/responses are queued as stimulus is accepted.
module tb_calf_nic;

    localparam int INJ_DEPTH = 4;
    localparam int EJ_DEPTH  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_dest;
    logic [3:0]   req_mshr;
    logic [127:0] req_data;
    logic [143:0] port4_ci;
    logic         port4_ready;
    logic         port4_ack;
    logic [143:0] port4_co;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [3:0]   rsp_src;
    logic [3:0]   rsp_mshr;
    logic [2:0]   rsp_seq;
    logic [127:0] rsp_data;
    logic [7:0]   drop_count;

    int checks = 0;
    int errors = 0;

    logic [143:0] inj_q[$];
    logic [138:0] ej_q[$];
    logic [2:0]   m_seq;
    logic [7:0]   m_drop;
    int unsigned  m_pushes;

    localparam logic [127:0] PAY = 128'h0123456789abcdef0123456789abcdef;

    calf_nic #(
        .NODE_ID   (4'd5),
        .INJ_DEPTH (INJ_DEPTH),
        .EJ_DEPTH  (EJ_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dest    (req_dest),
        .req_mshr    (req_mshr),
        .req_data    (req_data),
        .port4_ci    (port4_ci),
        .port4_ready (port4_ready),
        .port4_ack   (port4_ack),
        .port4_co    (port4_co),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_src     (rsp_src),
        .rsp_mshr    (rsp_mshr),
        .rsp_seq     (rsp_seq),
        .rsp_data    (rsp_data),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; the scoreboard records what the current inputs should cause at this edge.
    task automatic tick();
        bit acc, ipop, epop;
        #1;
        acc  = req_valid && !rst && (inj_q.size() < INJ_DEPTH);
        ipop = port4_ready && port4_ack && (inj_q.size() > 0);
        epop = rsp_ready && (ej_q.size() > 0);
        if (rst) begin
            inj_q.delete();
            ej_q.delete();
            m_seq    = 3'd0;
            m_drop   = 8'd0;
            m_pushes = 0;
        end else begin
            if (ipop) void'(inj_q.pop_front());
            if (acc) begin
                inj_q.push_back({req_data, req_mshr, 1'b1, m_seq, 4'd5, req_dest});
                m_seq    = m_seq + 3'd1;
                m_pushes = m_pushes + 1;
            end
            if (epop) void'(ej_q.pop_front());
            if (port4_co[11]) begin
                if (ej_q.size() < EJ_DEPTH)
                    ej_q.push_back({port4_co[143:16], port4_co[15:12], port4_co[10:8], port4_co[7:4]});
                else if (m_drop != 8'hff)
                    m_drop = m_drop + 8'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_dest    = 4'd0;
        req_mshr    = 4'd0;
        req_data    = '0;
        port4_ready = 1'b0;
        port4_ack   = 1'b0;
        port4_co    = '0;
        rsp_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        tick();
        tick();
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (port4_ci !== '0) begin errors++; $display("FAIL reset_ci got %h exp 0", port4_ci); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++;
        if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 1'b1; req_dest = 4'd7; req_mshr = 4'd1; req_data = PAY;
        port4_ready = 1'b1; port4_ack = 1'b1;
        tick();
        req_valid = 1'b0;
        #1;
        checks++;
        if (port4_ci !== {PAY, 16'h1857}) begin errors++; $display("FAIL single_flit got %h exp %h", port4_ci, {PAY, 16'h1857}); end
        checks++;
        if (inj_q.size() == 0 || port4_ci !== inj_q[0]) begin errors++; $display("FAIL single_sb got %h", port4_ci); end
        tick();
        #1;
        checks++;
        if (port4_ci !== '0) begin errors++; $display("FAIL single_idle got %h exp 0", port4_ci); end
    endtask

    task automatic test_hold();
        do_reset();
        req_valid = 1'b1; req_dest = 4'd7; req_mshr = 4'd1; req_data = PAY;
        port4_ready = 1'b1; port4_ack = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) req_valid = 1'b0;
            if (i == 3) port4_ack = 1'b1;
            #1;
            checks++;
            if (port4_ci !== {PAY, 16'h1857}) begin errors++; $display("FAIL hold_c%0d got %h exp %h", i, port4_ci, {PAY, 16'h1857}); end
            tick();
        end
        port4_ack = 1'b0;
        #1;
        checks++;
        if (port4_ci !== {PAY, 16'h1957}) begin errors++; $display("FAIL hold_second got %h exp %h", port4_ci, {PAY, 16'h1957}); end
        port4_ack = 1'b1;
        tick();
        port4_ack = 1'b0;
        #1;
        checks++;
        if (port4_ci !== '0) begin errors++; $display("FAIL hold_drained got %h exp 0", port4_ci); end
    endtask

    task automatic test_fill_seq();
        do_reset();
        port4_ready = 1'b0; port4_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_dest  = 4'($urandom_range(0, 15));
            req_mshr  = 4'(i);
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++;
            if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1", i, req_ready); end
            checks++;
            if (port4_ci !== '0) begin errors++; $display("FAIL fill_ci%0d got %h exp 0", i, port4_ci); end
            tick();
        end
        port4_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [2:0] exp_seq;
            exp_seq   = 3'(i);
            req_valid = (m_pushes < 9);
            req_mshr  = 4'(m_pushes);
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++;
            if (req_ready !== (inj_q.size() < INJ_DEPTH)) begin errors++; $display("FAIL seq_ready%0d got %b", i, req_ready); end
            checks++;
            if (port4_ci[10:8] !== exp_seq) begin errors++; $display("FAIL seq_walk%0d got %0d exp %0d", i, port4_ci[10:8], exp_seq); end
            checks++;
            if (inj_q.size() == 0 || port4_ci !== inj_q[0]) begin errors++; $display("FAIL seq_flit%0d got %h", i, port4_ci); end
            tick();
        end
        req_valid = 1'b0;
        #1;
        checks++;
        if (port4_ci !== '0) begin errors++; $display("FAIL seq_empty got %h exp 0", port4_ci); end
    endtask

    task automatic test_eject();
        do_reset();
        port4_co = {PAY, 16'h284c};
        tick();
        port4_co = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ej_valid got %b exp 1", rsp_valid); end
        checks++;
        if ({rsp_mshr, rsp_seq, rsp_src} !== {4'd2, 3'd0, 4'd4}) begin errors++; $display("FAIL ej_fields got %h/%h/%h exp 2/0/4", rsp_mshr, rsp_seq, rsp_src); end
        checks++;
        if (ej_q.size() == 0 || {rsp_data, rsp_mshr, rsp_seq, rsp_src} !== ej_q[0]) begin errors++; $display("FAIL ej_sb got %h", rsp_data); end
        rsp_ready = 1'b1;
        tick();
        port4_co = {PAY, 16'h2744};
        tick();
        port4_co = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ej_invalid got %b exp 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            port4_co = {$urandom, $urandom, $urandom, $urandom, 4'($urandom), 1'b1, 3'($urandom), 4'($urandom), 4'd5};
            tick();
        end
        port4_co = '0;
        #1;
        checks++;
        if (drop_count !== 8'd2) begin errors++; $display("FAIL drop_two got %0d exp 2", drop_count); end
        port4_co  = {PAY, 16'h7a35};
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (ej_q.size() == 0 || {rsp_data, rsp_mshr, rsp_seq, rsp_src} !== ej_q[0]) begin errors++; $display("FAIL drop_head got %h", rsp_data); end
        tick();
        port4_co  = '0;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (drop_count !== 8'd2) begin errors++; $display("FAIL drop_fullpop got %0d exp 2", drop_count); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (rsp_valid !== (ej_q.size() > 0)) begin errors++; $display("FAIL drain_valid%0d got %b", i, rsp_valid); end
            if (ej_q.size() > 0) begin
                checks++;
                if ({rsp_data, rsp_mshr, rsp_seq, rsp_src} !== ej_q[0]) begin errors++; $display("FAIL drain%0d got %h %h exp %h", i, rsp_data, {rsp_mshr, rsp_seq, rsp_src}, ej_q[0]); end
            end
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 270; i++) begin
            port4_co = {PAY, 4'd3, 1'b1, 3'(i), 4'd2, 4'd5};
            tick();
        end
        port4_co = '0;
        #1;
        checks++;
        if (drop_count !== 8'd255 || drop_count !== m_drop) begin errors++; $display("FAIL drop_sat got %0d exp 255", drop_count); end
    endtask

    task automatic test_reset_mid();
        port4_ready = 1'b0;
        port4_ack   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_dest = 4'd2; req_mshr = 4'(i); req_data = PAY;
            tick();
        end
        req_valid   = 1'b0;
        port4_ready = 1'b1;
        #1;
        checks++;
        if (port4_ci === '0) begin errors++; $display("FAIL mid_offered got %h exp nonzero", port4_ci); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (port4_ci !== '0) begin errors++; $display("FAIL mid_ci got %h exp 0", port4_ci); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp got %b exp 0", rsp_valid); end
        checks++;
        if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_drop got %0d exp 0", drop_count); end
        req_valid = 1'b1; req_dest = 4'd9; req_mshr = 4'd6; req_data = PAY;
        tick();
        req_valid = 1'b0;
        #1;
        checks++;
        if (port4_ci[10:8] !== 3'd0) begin errors++; $display("FAIL mid_seq got %0d exp 0", port4_ci[10:8]); end
        checks++;
        if (inj_q.size() == 0 || port4_ci !== inj_q[0]) begin errors++; $display("FAIL mid_flit got %h", port4_ci); end
    endtask

    initial begin
        m_seq    = 3'd0;
        m_drop   = 8'd0;
        m_pushes = 0;
        test_reset();
        test_single();
        test_hold();
        test_fill_seq();
        test_eject();
        test_drop();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calf_nic.md
Name: calf_nic

Overview:
- Node-side network interface for the bufferless CALF router. It is the local end of the router's injection/ejection port 4.
- Injection: queues local client requests, formats them as 144-bit flits and offers them on the router's injection input under the ready/ack handshake.
- Ejection: captures flits the router ejects to this node and buffers them toward the local client, which can backpressure.

Parameters:
- NODE_ID, 0, 4-bit node address written into the flit source field.
- INJ_DEPTH, 4, injection FIFO entries (power of 2, ≥2).
- EJ_DEPTH, 4, ejection FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  client request present.
- req_ready  out  1  injection FIFO can accept.
- req_dest  in  4  destination node.
- req_mshr  in  4  MSHR tag.
- req_data  in  128  payload.
- port4_ci  out  144  injection flit to router; all-zero when idle.
- port4_ready  in  1  router has an injection slot this cycle.
- port4_ack  in  1  router consumes the flit on port4_ci at this edge.
- port4_co  in  144  ejected flit from router.
- rsp_valid  out  1  ejected flit available.
- rsp_ready  in  1  client takes the response.
- rsp_src  out  4  source field.
- rsp_mshr  out  4  MSHR field.
- rsp_seq  out  3  sequence field.
- rsp_data  out  128  payload.
- drop_count  out  8  saturating count of ejected flits lost to a full EJ FIFO.

Behaviour:
- Flit format: [143:16] payload; [15:12] MSHR; [11] valid; [10:8] seq; [7:4] source; [3:0] dest.
- Reset (sync, rst=1 at edge): both FIFOs empty; seq counter = 0; drop_count = 0; port4_ci = 0; rsp_valid = 0; req_ready = 0 while rst is high.
- Reset mid-operation: any in-flight offered flit is abandoned. The router must not see it acked, because port4_ci is 0 in the cycle after reset.
- Request accept: req_valid & req_ready at edge N pushes {data, mshr, dest} into the INJ FIFO. req_ready = !inj_full (registered-state derived, combinational).
- Injection offer: the FIFO head and port4_ready are combinational to port4_ci.
  - When inj non-empty & port4_ready: port4_ci = {head.data, head.mshr, 1'b1, seq, NODE_ID, head.dest}.
  - Otherwise port4_ci = 0.
  - Earliest offer is cycle N+1.
- Injection completion: at an edge with port4_ack=1 while a flit is offered, pop the INJ FIFO and increment seq (3-bit, 7→0 wrap).
  - port4_ack while nothing is offered is ignored.
  - Offered but not acked: the same flit with the same seq is re-offered whenever port4_ready is high.
- Simultaneous push and pop on the INJ FIFO is legal at any occupancy, including full when popping. req_ready still reflects pre-edge full.
- Ejection capture: at each edge where port4_co[11]=1, push {port4_co[143:16], [15:12], [10:8], [7:4]} into the EJ FIFO.
  - The destination field is not rechecked.
  - Flits with bit 11 = 0 are ignored.
- EJ full: the push succeeds if the same edge pops (rsp_valid & rsp_ready). Otherwise the flit is dropped and drop_count increments, saturating at 255.
- Response: rsp_valid = !ej_empty; rsp_* = EJ head. Latency is port4_co valid in cycle M → rsp_valid in cycle M+1. The pop happens on rsp_valid & rsp_ready.
- No combinational path from port4_co to any output.

Decomposition:
- Package calf_nic_pkg holds:
  - constants FLIT_W=144, PAYLOAD_W=128;
  - field LSB/MSB constants for MSHR/valid/seq/src/dest;
  - flit_pack and flit_unpack functions.
- Sub-module calf_nic_fifo: generic synchronous FIFO (WIDTH, DEPTH) with full/empty, same-cycle push+pop, and sync reset. It is instantiated for both INJ and EJ.

Test Plan:
1. NODE_ID=5; request dest=7, mshr=1, data=0123456789abcdef0123456789abcdef; port4_ready=port4_ack=1 → next cycle port4_ci=144'h0123456789abcdef0123456789abcdef1857; seq becomes 1.
2. Same request twice with port4_ready=1 and port4_ack=0 for 3 cycles, then ack=1 → flit 0x...1857 is held unchanged for 4 cycles; the second flit is then offered as 0x...1957.
3. Fill INJ with 4 requests while port4_ready=0 → req_ready=0 after the 4th; port4_ci=0 throughout. Then 9 acked injections → seq walks 0..7,0.
4. port4_co=144'h0123456789abcdef0123456789abcdef284c → next cycle rsp_valid=1, rsp_mshr=2, rsp_seq=0, rsp_src=4. A flit with bit 11 = 0 → no response.
5. rsp_ready=0; eject 6 valid flits → 4 buffered, drop_count=2. Eject with EJ full and rsp_ready=1 the same cycle → no drop.
6. Assert rst for 1 cycle with 2 queued and 1 offered → port4_ci=0, rsp_valid=0, drop_count=0, and the next injected flit has seq 0.
